// File: rtl/fp_multicycle_ctrl.sv
// fp_multicycle_ctrl
//
// EX-stage sequencer for multi-cycle floating-point operations. While an FP
// add, mul or div is in flight it requests a stall of F/D/E from the hazard
// unit. When the operation finishes it emits a one-cycle registered
// completion pulse, with the destination register, into MEM.
//
// Optional feature macro: FP_DIV_EN
//   defined   : op 10 (div) is a multi-cycle op of latency LAT_DIV and
//               FpIllegalM is constant 0.
//   undefined : op 10 completes like a single-cycle op and raises
//               FpIllegalM together with its FpDoneM. No divide latency
//               path exists.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   FpStartE    valid FP instruction present in EX
//   FpOpE[1:0]  00 add/sub, 01 mul, 10 div, 11 single-cycle
//   FRdE[4:0]   FP destination register of the EX instruction
//   FlushE      flush of EX from the hazard unit
//   StallReqE   combinational stall request to the hazard unit
//   FpBusy      high while an op is in flight (BUSY state, doubles as the
//               state debug view)
//   FpDoneM     registered one-cycle completion pulse
//   FpRdM[4:0]  destination of the completing op (valid with FpDoneM)
//   FpOpM[1:0]  op class of the completing op
//   FpIllegalM  registered; pulses with FpDoneM for an unsupported op
//   StallCount  saturating count of cycles with StallReqE=1
//
// Handshake: an op is accepted in a cycle where the block is idle,
// FpStartE=1 and FlushE=0. A multi-cycle op keeps StallReqE high for L-1
// cycles, starting with the accept cycle, and FpDoneM pulses L cycles after
// the accept. FpStartE is ignored while busy because the stalled instruction
// is the one already accepted.
module fp_multicycle_ctrl #(
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 12,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FpStartE,
    input  logic [1:0]  FpOpE,
    input  logic [4:0]  FRdE,
    input  logic        FlushE,
    output logic        StallReqE,
    output logic        FpBusy,
    output logic        FpDoneM,
    output logic [4:0]  FpRdM,
    output logic [1:0]  FpOpM,
    output logic        FpIllegalM,
    output logic [15:0] StallCount
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Every latency must be at least 2 and must fit in the down-counter.
    localparam int  CNT_MAX = (1 << CNT_W) - 1;
    localparam bit  LAT_OK  = (LAT_ADD >= 2) && (LAT_ADD <= CNT_MAX) &&
                              (LAT_MUL >= 2) && (LAT_MUL <= CNT_MAX) &&
                              (LAT_DIV >= 2) && (LAT_DIV <= CNT_MAX);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;
    logic [1:0]       op_q;

    logic             accept;
    logic             is_multi;
    logic             illegal_op;
    logic [CNT_W-1:0] load_val;

    // Op decode: which ops occupy EX for several cycles, and the counter
    // preload (L-1) that makes the final busy cycle the one with cnt==1.
    always_comb begin
        is_multi = 1'b0;
        load_val = '0;
        case (FpOpE)
            2'b00: begin
                is_multi = 1'b1;
                load_val = CNT_W'(LAT_ADD - 1);
            end
            2'b01: begin
                is_multi = 1'b1;
                load_val = CNT_W'(LAT_MUL - 1);
            end
`ifdef FP_DIV_EN
            2'b10: begin
                is_multi = 1'b1;
                load_val = CNT_W'(LAT_DIV - 1);
            end
`endif
            default: begin
                is_multi = 1'b0;
                load_val = '0;
            end
        endcase
    end

`ifdef FP_DIV_EN
    assign illegal_op = 1'b0;
`else
    assign illegal_op = (FpOpE == 2'b10);
`endif

    assign accept = (state == S_IDLE) && FpStartE && !FlushE;

    // The last busy cycle (cnt==1) drops the stall so the held instruction
    // advances; a flush also drops it because the op is being killed.
    assign StallReqE = !reset &&
                       ((accept && is_multi) ||
                        ((state == S_BUSY) && (cnt > CNT_ONE) && !FlushE));

    assign FpBusy = (state == S_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            FpDoneM    <= 1'b0;
            FpIllegalM <= 1'b0;
            FpRdM      <= '0;
            FpOpM      <= '0;
            StallCount <= '0;
        end else begin
            FpDoneM    <= 1'b0;
            FpIllegalM <= 1'b0;

            if (StallReqE && (StallCount != 16'hFFFF)) begin
                StallCount <= StallCount + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_multi) begin
                            state <= S_BUSY;
                            cnt   <= load_val;
                            rd_q  <= FRdE;
                            op_q  <= FpOpE;
                        end else begin
                            FpDoneM    <= 1'b1;
                            FpRdM      <= FRdE;
                            FpOpM      <= FpOpE;
                            FpIllegalM <= illegal_op;
                        end
                    end
                end
                S_BUSY: begin
                    // Flush has priority over a completion in the same cycle.
                    if (FlushE) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_ONE) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        FpDoneM <= 1'b1;
                        FpRdM   <= rd_q;
                        FpOpM   <= op_q;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Catches an out-of-range latency parameterisation during simulation.
    always @(posedge clk) begin
        lat_cfg_ok: assert (LAT_OK);
    end

endmodule

// File: tb/tb_fp_multicycle_ctrl.sv
// tb_fp_multicycle_ctrl
//
// Bench for fp_multicycle_ctrl. A timeline model (accept cycle + latency,
// pending completion, stall tally) predicts every output in every cycle.
// Directed scenarios pin the model with literal expectations, and a random
// phase follows. Honors FP_DIV_EN the same way the design does.
module tb_fp_multicycle_ctrl;

    localparam int LA = 3;
    localparam int LM = 4;
    localparam int LD = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        FpStartE;
    logic [1:0]  FpOpE;
    logic [4:0]  FRdE;
    logic        FlushE;
    logic        StallReqE;
    logic        FpBusy;
    logic        FpDoneM;
    logic [4:0]  FpRdM;
    logic [1:0]  FpOpM;
    logic        FpIllegalM;
    logic [15:0] StallCount;

    fp_multicycle_ctrl #(
        .LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .FpStartE(FpStartE), .FpOpE(FpOpE),
        .FRdE(FRdE), .FlushE(FlushE), .StallReqE(StallReqE), .FpBusy(FpBusy),
        .FpDoneM(FpDoneM), .FpRdM(FpRdM), .FpOpM(FpOpM),
        .FpIllegalM(FpIllegalM), .StallCount(StallCount)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Latency of an op class, 0 meaning it completes in one cycle.
    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00: return LA;
            2'b01: return LM;
`ifdef FP_DIV_EN
            2'b10: return LD;
`endif
            default: return 0;
        endcase
    endfunction

    // ---------------- behavioural model + compare ----------------
    bit         m_busy   = 0;
    int         m_acc    = 0;
    int         m_lat    = 0;
    logic [4:0] m_rd     = '0;
    logic [1:0] m_op     = '0;
    bit         m_done   = 0;
    bit         m_ill    = 0;
    logic [4:0] m_out_rd = '0;
    logic [1:0] m_out_op = '0;
    int         m_cnt    = 0;

    always @(negedge clk) begin : model
        bit acc;
        bit e_stall;
        int l;
        l       = lat_of(FpOpE);
        acc     = !m_busy && FpStartE && !FlushE;
        e_stall = !reset && ((acc && (l != 0)) ||
                             (m_busy && (cyc < m_acc + m_lat - 1) && !FlushE));

        chk("stall_req", StallReqE, e_stall);
        chk("busy", FpBusy, m_busy);
        chk("done", FpDoneM, m_done);
        chk("illegal", FpIllegalM, m_ill);
        chk("rd_m", FpRdM, m_out_rd);
        chk("op_m", FpOpM, m_out_op);
        chk("stall_count", StallCount, m_cnt);

        if (reset) begin
            m_busy = 0; m_done = 0; m_ill = 0;
            m_out_rd = '0; m_out_op = '0; m_cnt = 0;
        end else begin
            if (e_stall && m_cnt < 65535) m_cnt++;
            m_done = 0;
            m_ill  = 0;
            if (m_busy) begin
                if (FlushE) begin
                    m_busy = 0;
                end else if (cyc == m_acc + m_lat - 1) begin
                    m_busy = 0; m_done = 1;
                    m_out_rd = m_rd; m_out_op = m_op;
                end
            end else if (acc) begin
                if (l != 0) begin
                    m_busy = 1; m_acc = cyc; m_lat = l;
                    m_rd = FRdE; m_op = FpOpE;
                end else begin
                    m_done = 1; m_out_rd = FRdE; m_out_op = FpOpE;
`ifdef FP_DIV_EN
                    m_ill = 0;
`else
                    m_ill = (FpOpE == 2'b10);
`endif
                end
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    task automatic drive(input bit s, input logic [1:0] o, input logic [4:0] r,
                         input bit f, input bit rs);
        @(posedge clk);
        #1;
        FpStartE = s; FpOpE = o; FRdE = r; FlushE = f; reset = rs;
    endtask

    task automatic do_reset();
        drive(0, 2'b00, 5'd0, 0, 1);
        drive(0, 2'b00, 5'd0, 0, 1);
        @(negedge clk);
        chk("rst_busy", FpBusy, 0);
        chk("rst_done", FpDoneM, 0);
        chk("rst_count", StallCount, 0);
        chk("rst_rd", FpRdM, 0);
    endtask

    initial begin
        reset = 1; FpStartE = 0; FpOpE = 2'b00; FRdE = '0; FlushE = 0;
        do_reset();

        // Mul, rd 7: stall cycles 0-2, done in cycle 4, three stall cycles.
        for (int k = 0; k <= 5; k++) begin
            drive(k <= 3, 2'b01, 5'd7, 0, 0);
            @(negedge clk);
            chk("t1_stall", StallReqE, k < 3);
            chk("t1_done", FpDoneM, k == 4);
            if (k == 4) begin
                chk("t1_rd", FpRdM, 7);
                chk("t1_op", FpOpM, 1);
                chk("t1_count", StallCount, 3);
            end
        end

        // Single-cycle op 11, rd 3: done in cycle 1, no stall.
        do_reset();
        for (int k = 0; k <= 2; k++) begin
            drive(k == 0, 2'b11, 5'd3, 0, 0);
            @(negedge clk);
            chk("t2_stall", StallReqE, 0);
            chk("t2_done", FpDoneM, k == 1);
            if (k == 1) chk("t2_rd", FpRdM, 3);
        end

        // Div, rd 12.
        do_reset();
`ifdef FP_DIV_EN
        for (int k = 0; k <= 13; k++) begin
            drive(k <= 11, 2'b10, 5'd12, 0, 0);
            @(negedge clk);
            chk("t3_stall", StallReqE, k <= 10);
            chk("t3_done", FpDoneM, k == 12);
            chk("t3_ill", FpIllegalM, 0);
        end
`else
        for (int k = 0; k <= 2; k++) begin
            drive(k == 0, 2'b10, 5'd12, 0, 0);
            @(negedge clk);
            chk("t3_stall", StallReqE, 0);
            chk("t3_done", FpDoneM, k == 1);
            chk("t3_ill", FpIllegalM, k == 1);
            if (k == 1) chk("t3_rd", FpRdM, 12);
        end
`endif

        // Mul flushed in cycle 2: stall drops, busy clears, no completion.
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            drive(k < 2, 2'b01, 5'd9, k == 2, 0);
            @(negedge clk);
            chk("t4_stall", StallReqE, k < 2);
            chk("t4_busy", FpBusy, (k >= 1) && (k <= 2));
            chk("t4_done", FpDoneM, 0);
        end

        // Add with flush in the accept cycle: never accepted.
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            drive(k == 0, 2'b00, 5'd4, k == 0, 0);
            @(negedge clk);
            chk("t5_stall", StallReqE, 0);
            chk("t5_busy", FpBusy, 0);
            chk("t5_done", FpDoneM, 0);
        end

        // Reset in the middle of a long op: nothing survives.
        do_reset();
        begin
`ifdef FP_DIV_EN
            logic [1:0] rop = 2'b10;
            int rc = 4;
`else
            logic [1:0] rop = 2'b01;
            int rc = 2;
`endif
            for (int k = 0; k <= rc + 12; k++) begin
                drive(k < rc, rop, 5'd5, 0, k == rc);
                @(negedge clk);
                if (k > rc) begin
                    chk("t6_busy", FpBusy, 0);
                    chk("t6_stall", StallReqE, 0);
                    chk("t6_done", FpDoneM, 0);
                    chk("t6_count", StallCount, 0);
                end
            end
        end

        // Random traffic checked against the model.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 9) < 6,
                  2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 199) == 0);
        end

        drive(0, 2'b00, 5'd0, 0, 0);
        drive(0, 2'b00, 5'd0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
